// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - request-type encodings, size masks and FSM states for the load/store unit
package lsu_pkg;

    localparam logic [2:0] TYPE_B  = 3'b000;
    localparam logic [2:0] TYPE_H  = 3'b001;
    localparam logic [2:0] TYPE_W  = 3'b010;
    localparam logic [2:0] TYPE_BU = 3'b100;
    localparam logic [2:0] TYPE_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    // Byte-lane mask of an access at offset 0; zero marks an illegal encoding.
    function automatic logic [3:0] size_mask(input logic [2:0] t);
        case (t)
            TYPE_B, TYPE_BU: size_mask = MASK_B;
            TYPE_H, TYPE_HU: size_mask = MASK_H;
            TYPE_W:          size_mask = MASK_W;
            default:         size_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - pipeline request/response and memory beat interfaces
// lsu_req_if: master = pipeline, slave = lsu_ctrl.
// lsu_mem_if: master = lsu_ctrl, slave = memory.
interface lsu_req_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_type;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (output req_valid, req_we, req_addr, req_type, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_we, req_addr, req_type, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 32);
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    input  mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane shift, byte-enable generation and load extension
// Ports: off_i/type_i/wdata_i describe the access; rdata_lo_i/rdata_hi_i are beat 0/1 data.
//        illegal_o, split_o, be0_o/be1_o, wdata0_o/wdata1_o per beat, load_o merged result.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  type_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_lo_i,
    input  logic [31:0] rdata_hi_i,
    output logic        illegal_o,
    output logic        split_o,
    output logic [3:0]  be0_o,
    output logic [3:0]  be1_o,
    output logic [31:0] wdata0_o,
    output logic [31:0] wdata1_o,
    output logic [31:0] load_o
);
    logic [3:0]  mask;
    logic [2:0]  size;
    logic [7:0]  lanes;
    logic [63:0] wide_w;
    logic [63:0] wide_r;
    logic [31:0] m;

    always_comb begin
        mask      = size_mask(type_i);
        illegal_o = (mask == 4'b0000);
        size      = {2'b00, mask[0]} + {2'b00, mask[1]} + {2'b00, mask[2]} + {2'b00, mask[3]};
        split_o   = ({1'b0, off_i} + size) > 3'd4;
        // Shifting across an 8-lane / 64-bit window yields beat 0 in the low half
        // and the spill-over for beat 1 in the high half in one step.
        lanes     = {4'b0000, mask} << off_i;
        be0_o     = lanes[3:0];
        be1_o     = lanes[7:4];
        wide_w    = {32'h0, wdata_i} << {off_i, 3'b000};
        wdata0_o  = wide_w[31:0];
        wdata1_o  = wide_w[63:32];
        wide_r    = {rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000};
        m         = wide_r[31:0];
        case (type_i)
            TYPE_B:  load_o = {{24{m[7]}}, m[7:0]};
            TYPE_H:  load_o = {{16{m[15]}}, m[15:0]};
            TYPE_W:  load_o = m;
            TYPE_BU: load_o = {24'h0, m[7:0]};
            TYPE_HU: load_o = {16'h0, m[15:0]};
            default: load_o = 32'h0;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller splitting misaligned accesses into two word beats
// Ports: clk, rst_n (async active-low); req (lsu_req_if.slave) pipeline side;
//        mem (lsu_mem_if.master) word-aligned memory beat side.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
)(
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);
    state_t            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        type_q;
    logic [31:0]       wdata_q;
    logic [31:0]       beat0_q;
    logic [31:0]       beat1_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic              idle;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] base;
    logic [2:0]        sel_type;
    logic [31:0]       sel_wdata;
    logic [31:0]       rdata_lo;
    logic [31:0]       rdata_hi;
    logic              illegal;
    logic              split;
    logic [3:0]        be0;
    logic [3:0]        be1;
    logic [31:0]       wdata0;
    logic [31:0]       wdata1;
    logic [31:0]       load_data;

    // In IDLE the aligner looks at the incoming request so beat 0 can be
    // registered on the acceptance edge; afterwards it uses the latched copy.
    assign idle      = (state_q == S_IDLE);
    assign sel_addr  = idle ? req.req_addr  : addr_q;
    assign sel_type  = idle ? req.req_type  : type_q;
    assign sel_wdata = idle ? req.req_wdata : wdata_q;
    assign base      = {sel_addr[ADDR_W-1:2], 2'b00};
    // The beat arriving this cycle is merged directly so rsp_rdata registers on the same edge.
    assign rdata_lo  = (state_q == S_WAIT0) ? mem.mem_rdata : beat0_q;
    assign rdata_hi  = (state_q == S_WAIT1) ? mem.mem_rdata : beat1_q;

    lsu_align u_align (
        .off_i      (sel_addr[1:0]),
        .type_i     (sel_type),
        .wdata_i    (sel_wdata),
        .rdata_lo_i (rdata_lo),
        .rdata_hi_i (rdata_hi),
        .illegal_o  (illegal),
        .split_o    (split),
        .be0_o      (be0),
        .be1_o      (be1),
        .wdata0_o   (wdata0),
        .wdata1_o   (wdata1),
        .load_o     (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            type_q      <= 3'b000;
            wdata_q     <= 32'h0;
            beat0_q     <= 32'h0;
            beat1_q     <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req.req_valid) begin
                        we_q    <= req.req_we;
                        addr_q  <= req.req_addr;
                        type_q  <= req.req_type;
                        wdata_q <= req.req_wdata;
                        if (illegal) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                            state_q     <= S_RESP;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req.req_we;
                            mem_addr_q  <= base;
                            mem_be_q    <= be0;
                            mem_wdata_q <= wdata0;
                            state_q     <= S_REQ0;
                        end
                    end
                end
                S_REQ0: begin
                    if (mem.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_WAIT0;
                    end
                end
                S_WAIT0: begin
                    if (mem.mem_rvalid) begin
                        beat0_q <= mem.mem_rdata;
                        if (split) begin
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= base + ADDR_W'(4);
                            mem_be_q    <= be1;
                            mem_wdata_q <= wdata1;
                            state_q     <= S_REQ1;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= we_q ? 32'h0 : load_data;
                            state_q     <= S_RESP;
                        end
                    end
                end
                S_REQ1: begin
                    if (mem.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_WAIT1;
                    end
                end
                S_WAIT1: begin
                    if (mem.mem_rvalid) begin
                        beat1_q     <= mem.mem_rdata;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= we_q ? 32'h0 : load_data;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req.req_ready = idle;
    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_rdata = rsp_rdata_q;
    assign req.rsp_err   = rsp_err_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of req_addr and mem_addr.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  in  1  pipeline presents a load/store request.
REQ-005 req_ready  out  1  block accepts a request; transfer occurs when req_valid && req_ready.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  ADDR_W  byte address, any alignment.
REQ-008 req_type  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu; bu/hu apply to loads only.
REQ-009 req_wdata  in  32  store data, right-justified.
REQ-010 rsp_valid  out  1  one-cycle completion pulse; no back-pressure.
REQ-011 rsp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-012 rsp_err  out  1  illegal req_type (011, 110, 111), valid with rsp_valid.
REQ-013 mem_req  out  1  memory request.
REQ-014 mem_gnt  in  1  memory accepts the current request.
REQ-015 mem_we, mem_addr[ADDR_W], mem_be[4], mem_wdata[32]  out  beat control; mem_addr always word-aligned.
REQ-016 mem_rvalid  in  1, mem_rdata  in  32  beat completion, for both reads and writes; rdata meaningful for reads only.

Function
REQ-017 States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; an accepted request is latched in full and moves to REQ0, or to RESP with the error flag if req_type is illegal.
REQ-019 Size in bytes: b/bu = 1, h/hu = 2, w = 4. off = addr[1:0]. A request splits into two beats when off + size > 4. A byte access never splits.
REQ-020 Beat 0: mem_addr = addr & ~3; mem_be = (size mask << off) & 4'hF; mem_wdata = wdata << 8*off.
REQ-021 Beat 1: mem_addr = (addr & ~3) + 4, with modulo-2^ADDR_W wrap; mem_be = size mask >> (4 - off); mem_wdata = wdata >> 8*(4 - off).
REQ-022 mem_req SHALL be high in REQ0/REQ1, with mem_we/addr/be/wdata held stable until the cycle in which mem_gnt = 1; on that cycle the state moves to WAIT0/WAIT1.
REQ-023 mem_rvalid is sampled only in WAIT0/WAIT1 and is ignored in all other states; the earliest legal mem_rvalid is the cycle after mem_gnt.
REQ-024 WAIT0 + mem_rvalid: go to REQ1 if the access is split, otherwise to RESP; mem_rdata is captured as beat 0.
REQ-025 WAIT1 + mem_rvalid: capture mem_rdata as beat 1 and go to RESP.
REQ-026 Load merge: take {beat1, beat0} >> 8*off, keep the low size bytes, sign-extend for b/h, zero-extend for bu/hu/w.
REQ-027 RESP: rsp_valid = 1 for one cycle with registered rsp_rdata/rsp_err, then return to IDLE. A new request is accepted no earlier than the following cycle.
REQ-028 Latency, aligned, mem_gnt immediate, mem_rvalid the next cycle: acceptance edge at T, mem_req in T+1, mem_rvalid in T+2, rsp_valid in T+3. A split access adds 2 cycles.
REQ-029 Illegal req_type: rsp_err = 1 and rsp_valid = 1 in the cycle after acceptance, with no memory traffic.

Reset
REQ-030 rst_n low SHALL immediately force IDLE and drive all outputs to 0 except req_ready, which is 1 once in IDLE. Latched request and beat registers clear to 0.
REQ-031 Reset during REQx/WAITx abandons the access. A mem_rvalid arriving after reset release SHALL NOT produce rsp_valid.

Structure
REQ-032 Package lsu_pkg holds the req_type encodings, the size-mask constants and the state enumeration.
REQ-033 One combinational sub-module, lsu_align, holds the byte-lane shift, byte-enable generation and load extension. lsu_ctrl holds the FSM and registers.

Verification
REQ-034 lw 0x100; mem_rdata 0xDEADBEEF -> one beat, mem_addr 0x100, mem_be 1111; rsp_rdata 0xDEADBEEF at T+3.
REQ-035 lb 0x103, mem_rdata 0x80000000 -> mem_be 1000, rsp_rdata 0xFFFFFF80; lbu, same data -> 0x00000080.
REQ-036 lw 0x102; beat 0 at 0x100 returns 0x11223344, beat 1 at 0x104 returns 0x55667788 -> rsp_rdata 0x77881122 at T+5.
REQ-037 sh 0x103, wdata 0x0000ABCD -> beat 0: addr 0x100, be 1000, wdata 0xCD000000; beat 1: addr 0x104, be 0001, wdata 0x000000AB; rsp_rdata 0.
REQ-038 mem_gnt held low 5 cycles -> mem_req and beat signals stable, req_ready 0. req_type 011 -> rsp_err pulse at T+1, mem_req never asserted.
REQ-039 rst_n pulsed low in WAIT1, then mem_rvalid = 1 after release -> outputs 0 during reset, no rsp_valid, req_ready 1.
